// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the data memory: word width and the
// data-RAM transaction state encoding.
package cpu_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    DRAM_IDLE = 2'd0,
    DRAM_WAIT = 2'd1,
    DRAM_DONE = 2'd2
  } dram_state_e;

  // Counter preload for the WAIT state; the state itself accounts for one cycle.
  function automatic logic [3:0] wait_load(input int wait_cycles);
    if (wait_cycles <= 0) return 4'd0;
    return 4'(wait_cycles - 1);
  endfunction

endpackage

// File: rtl/data_ram_if.sv
// MEM-stage <-> data memory bus: request lines from the pipeline, status and
// read data back from the memory.
interface data_ram_if;
  import cpu_pkg::*;

  logic              ram_re;
  logic              ram_we;
  logic [31:0]       ram_address;
  logic [WORD_W-1:0] ram_data;
  logic              ram_busy;
  logic              ram_ready;
  logic [WORD_W-1:0] ram_rdata;
  logic              ram_misalign;

  modport master (
    output ram_re, ram_we, ram_address, ram_data,
    input  ram_busy, ram_ready, ram_rdata, ram_misalign
  );

  modport slave (
    input  ram_re, ram_we, ram_address, ram_data,
    output ram_busy, ram_ready, ram_rdata, ram_misalign
  );

endinterface

// File: rtl/data_ram_array.sv
// dram_array: single-port synchronous word array with write enable and a
// registered read port. Contents are not initialised.
module dram_array
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [2**ADDR_W];

  // Write on we; read-before-write registered output every cycle
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/data_ram.sv
// data_ram: fixed-latency data memory for the MEM stage. Captures one request
// in IDLE, waits WAIT_CYCLES, then commits the write or returns read data with
// a one-cycle ram_ready pulse. Optional macro DRAM_ALIGN_CHECK_EN flags and
// suppresses accesses whose byte address is not word aligned.
module data_ram
  import cpu_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic      clk,
  input  logic      rst,
  data_ram_if.slave bus
);

  localparam logic [3:0] WAIT_LOAD = wait_load(WAIT_CYCLES);

  dram_state_e       state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              capture;
  logic              commit;

  logic [ADDR_W-1:0] req_idx_p0;
  logic [WORD_W-1:0] req_wdata_p0;
  logic              req_we_p0;

  logic [ADDR_W-1:0] arr_idx;
  logic              arr_we;
  logic [WORD_W-1:0] arr_rdata;
  logic              suppress;

  logic              busy_p1;
  logic              ready_p1;
  logic [WORD_W-1:0] rdata_p1;

  logic              unused_addr_bits;
  assign unused_addr_bits = ^{bus.ram_address[31:ADDR_W+2], bus.ram_address[1:0]};

  // Next-state, counter and capture/commit strobes
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      DRAM_IDLE: begin
        if (bus.ram_re || bus.ram_we) begin
          capture = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d = DRAM_DONE;
          end else begin
            state_d = DRAM_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      DRAM_WAIT: begin
        if (cnt_q == 4'd0) state_d = DRAM_DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      DRAM_DONE: begin
        commit  = 1'b1;
        state_d = DRAM_IDLE;
      end
      default: state_d = DRAM_IDLE;
    endcase
  end

  // State and wait counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DRAM_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---- p0: request latch (authoritative copy for the whole transaction) ----
  always_ff @(posedge clk) begin
    if (capture) begin
      req_idx_p0   <= bus.ram_address[ADDR_W+1:2];
      req_wdata_p0 <= bus.ram_data;
      req_we_p0    <= bus.ram_we;
    end
  end

`ifdef DRAM_ALIGN_CHECK_EN
  logic misalign_p0;
  logic misalign_p1;

  // Latch the alignment flag alongside the request
  always_ff @(posedge clk) begin
    if (capture) misalign_p0 <= |bus.ram_address[1:0];
  end

  // Misalign pulse coincides with ram_ready
  always_ff @(posedge clk) begin
    if (rst) misalign_p1 <= 1'b0;
    else     misalign_p1 <= commit & misalign_p0;
  end

  assign suppress         = misalign_p0;
  assign bus.ram_misalign = misalign_p1;
`else
  assign suppress         = 1'b0;
  assign bus.ram_misalign = 1'b0;
`endif

  // In IDLE the array is addressed straight from the bus so that its
  // registered read already holds the word by the time DONE is reached,
  // even with WAIT_CYCLES = 0.
  assign arr_idx = (state_q == DRAM_IDLE) ? bus.ram_address[ADDR_W+1:2] : req_idx_p0;
  assign arr_we  = commit & req_we_p0 & ~suppress;

  dram_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .addr  (arr_idx),
    .wdata (req_wdata_p0),
    .rdata (arr_rdata)
  );

  // ---- p1: status and read-data outputs ----
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_p1  <= 1'b0;
      ready_p1 <= 1'b0;
      rdata_p1 <= '0;
    end else begin
      busy_p1  <= (state_d != DRAM_IDLE);
      ready_p1 <= commit;
      if (commit && !req_we_p0 && !suppress) rdata_p1 <= arr_rdata;
    end
  end

  assign bus.ram_busy  = busy_p1;
  assign bus.ram_ready = ready_p1;
  assign bus.ram_rdata = rdata_p1;

endmodule
